i2c_byte_master: RTL and testbench
==================================

Name: i2c_byte_master

Overview:
- Byte-level I2C master engine; replaces CPU bit-banging of SCL/SDA through the external register map.
- Sits directly downstream of the external memory-mapped register port. The CPU-facing register block issues one command at a time (START, WRITE byte, READ byte, STOP) and reads back the status and received data.
- Generates all SCL/SDA timing in hardware from a quarter-bit divider.

Parameters:
- P_QUARTER, 125, I_CLK cycles per quarter SCL period (125 at 50 MHz gives 100 kHz); minimum 2.
- P_DATA_WIDTH, 8, bits per transfer byte; fixed at 8 for I2C.

Ports:
- I_CLK  input  1  system clock.
- I_NRESET  input  1  asynchronous, active-low reset.
- I_CMD_VALID  input  1  command request; sampled only when O_CMD_READY=1.
- I_CMD  input  2  0=START, 1=WRITE, 2=READ, 3=STOP.
- I_DATA_TX  input  8  byte to send for WRITE; captured on accept.
- I_ACK_TX  input  1  ACK bit the master drives after READ (0=ACK, 1=NACK); captured on accept.
- O_CMD_READY  output  1  high in IDLE only.
- O_BUSY  output  1  high while a command executes.
- O_DONE  output  1  one-cycle pulse when a command completes.
- O_DATA_RX  output  8  last byte received by READ.
- O_ACK_RX  output  1  ACK sampled from the slave during WRITE (0=ACK).
- O_SCL  output  1  push-pull SCL.
- IO_SDA  inout  1  open-drain SDA: drives 0 or Z only.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-command):
  - O_SCL=1, SDA released, O_BUSY=0, O_CMD_READY=1, O_DONE=0, O_DATA_RX=0, O_ACK_RX=1.
  - FSM returns to IDLE and the quarter counter clears.
  - The bus may be left mid-transfer; software recovers by issuing STOP.
- Accept: I_CMD_VALID & O_CMD_READY on a rising edge.
  - I_CMD, I_DATA_TX and I_ACK_TX are captured.
  - The FSM leaves IDLE the next cycle, with O_BUSY=1 and O_CMD_READY=0 from that cycle on.
- While busy, I_CMD_VALID is ignored; commands are not queued.
- Quarter timer: counts 0..P_QUARTER-1. Each quarter Qn lasts P_QUARTER cycles, and outputs change only at quarter boundaries.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- START, 4 quarters:
  - Q0: SCL unchanged, SDA=1.
  - Q1: SCL=1, SDA=1.
  - Q2: SCL=1, SDA=0.
  - Q3: SCL=0, SDA=0.
  - Repeated start is legal.
- BIT, 8 bits, MSB first, 4 quarters each:
  - Q0: SCL=0, SDA=data bit (WRITE) or released (READ).
  - Q1: SCL=0.
  - Q2 and Q3: SCL=1.
  - READ samples IO_SDA on the last cycle of Q2 into a shift register.
- ACK, 4 quarters, same timing as a data bit:
  - WRITE: SDA released; O_ACK_RX is sampled at end of Q2.
  - READ: SDA driven with the captured I_ACK_TX; O_DATA_RX updates at end of ACK Q3.
- STOP, 4 quarters:
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=1, SDA=0.
  - Q2 and Q3: SCL=1, SDA=1.
- DONE: lasts 1 cycle; O_DONE=1 and O_BUSY=0, then IDLE.
- Command durations from first busy cycle to DONE:
  - START and STOP: 4*P_QUARTER cycles.
  - WRITE and READ: 36*P_QUARTER cycles.
- No protocol sequencing check: WRITE/READ without a prior START and STOP from idle both execute as specified.
- SCL stays 0 between byte commands; it is 1 only after STOP or reset.
- O_DATA_RX and O_ACK_RX hold until overwritten by the next READ or WRITE respectively.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- When defined:
  - Adds input I_SCL_IN (1 bit, synchronised through 2 flops internally).
  - Entering any quarter with SCL=1 holds the quarter counter while synchronised I_SCL_IN=0, so slave clock stretching extends the high phase.
  - Sampling points shift accordingly.
- When undefined: no I_SCL_IN port; timing is strictly fixed.

Test Plan:
- P_QUARTER=4, reset then idle: O_SCL=1, SDA=Z, O_CMD_READY=1; START accepted -> O_BUSY for 16 cycles, O_DONE pulse on cycle 17, SDA falls while SCL=1.
- WRITE 0xA5 with slave model ACKing -> SDA bits 1,0,1,0,0,1,0,1 at SCL rising edges, O_ACK_RX=0, O_DONE 144 cycles after the first busy cycle.
- WRITE 0x3C with no slave (SDA pulled up) -> O_ACK_RX=1.
- READ with slave returning 0x5E, I_ACK_TX=1 -> O_DATA_RX=0x5E, SDA released in the ACK slot; I_CMD_VALID asserted mid-READ ignored (O_CMD_READY=0, no extra O_DONE).
- STOP after WRITE -> SCL rises before SDA rises, final O_SCL=1 and SDA=Z; I_NRESET asserted mid-WRITE -> all outputs at reset values immediately, asynchronously.
- With I2C_CLK_STRETCH_EN: hold I_SCL_IN=0 for 20 cycles during bit 3 high phase -> WRITE duration extends by 20 cycles plus synchroniser latency, data still correct.

Source files
------------

// File: rtl/i2c_byte_master_if.sv
// Command/status and SCL bundle between the CPU-facing register block
// (master modport) and the I2C byte engine (slave modport).
`timescale 1ns/1ps

interface i2c_byte_master_if #(
    parameter int P_DATA_WIDTH = 8
);
    logic                    I_CMD_VALID;
    logic [1:0]              I_CMD;
    logic [P_DATA_WIDTH-1:0] I_DATA_TX;
    logic                    I_ACK_TX;
    logic                    O_CMD_READY;
    logic                    O_BUSY;
    logic                    O_DONE;
    logic [P_DATA_WIDTH-1:0] O_DATA_RX;
    logic                    O_ACK_RX;
    logic                    O_SCL;

    modport master (
        output I_CMD_VALID, I_CMD, I_DATA_TX, I_ACK_TX,
        input  O_CMD_READY, O_BUSY, O_DONE, O_DATA_RX, O_ACK_RX, O_SCL
    );

    modport slave (
        input  I_CMD_VALID, I_CMD, I_DATA_TX, I_ACK_TX,
        output O_CMD_READY, O_BUSY, O_DONE, O_DATA_RX, O_ACK_RX, O_SCL
    );
endinterface

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master engine: executes one START / WRITE / READ / STOP
// command at a time, generating SCL/SDA from a quarter-bit timer.
// Optional feature macro: I2C_CLK_STRETCH_EN adds I_SCL_IN and lets a slave
// stretch the SCL high phase.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a command, O_CMD_READY=1, bus lines held
//   S_START | 4 quarters of (repeated) START condition
//   S_BIT   | 8 data bits, MSB first, 4 quarters each
//   S_ACK   | 9th clock: slave ACK (WRITE) or master ACK/NACK (READ)
//   S_STOP  | 4 quarters of STOP condition
//   S_DONE  | single cycle, O_DONE=1, back to S_IDLE
`timescale 1ns/1ps

module i2c_byte_master #(
    parameter int P_QUARTER    = 125,
    parameter int P_DATA_WIDTH = 8
) (
    input  logic               I_CLK,
    input  logic               I_NRESET,
    inout  wire                IO_SDA,
`ifdef I2C_CLK_STRETCH_EN
    input  logic               I_SCL_IN,
`endif
    i2c_byte_master_if.slave   bus
);

    localparam int QW = (P_QUARTER > 1) ? $clog2(P_QUARTER) : 1;
    localparam int BW = $clog2(P_DATA_WIDTH);
    localparam logic [QW-1:0] Q_LAST   = QW'(P_QUARTER - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(P_DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e                  state_q,   state_d;
    logic [QW-1:0]           qcnt_q,    qcnt_d;
    logic [1:0]              quarter_q, quarter_d;
    logic [BW-1:0]           bit_q,     bit_d;
    cmd_e                    cmd_q,     cmd_d;
    logic [P_DATA_WIDTH-1:0] tx_q,      tx_d;
    logic                    ack_tx_q,  ack_tx_d;
    logic [P_DATA_WIDTH-1:0] rx_sh_q,   rx_sh_d;
    logic [P_DATA_WIDTH-1:0] data_rx_q, data_rx_d;
    logic                    ack_rx_q,  ack_rx_d;
    logic                    scl_q,     scl_d;
    logic                    sda_low_q, sda_low_d;

    logic                    q_enter;
    logic                    q_last;
    logic                    hold;
    wire                     sda_in;

    // SDA is only ever sampled in the middle of the SCL-high phase, where the
    // slave guarantees it stable, so it is read without a synchroniser.
    assign sda_in = IO_SDA;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync_q;

    // Two-flop synchroniser for the externally observed SCL line.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            scl_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I_SCL_IN};
        end
    end

    // Freeze the quarter timer while we release SCL high but a slave holds it low.
    assign hold = scl_q && !scl_sync_q[1];
`else
    assign hold = 1'b0;
`endif

    // State and datapath register; reset takes effect immediately.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            cmd_q     <= CMD_START;
            tx_q      <= '0;
            ack_tx_q  <= 1'b1;
            rx_sh_q   <= '0;
            data_rx_q <= '0;
            ack_rx_q  <= 1'b1;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_d;
            tx_q      <= tx_d;
            ack_tx_q  <= ack_tx_d;
            rx_sh_q   <= rx_sh_d;
            data_rx_q <= data_rx_d;
            ack_rx_q  <= ack_rx_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    // Next-state, quarter sequencing, sampling and registered line levels.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        ack_tx_d  = ack_tx_q;
        rx_sh_d   = rx_sh_q;
        data_rx_d = data_rx_q;
        ack_rx_d  = ack_rx_q;
        scl_d     = scl_q;
        sda_low_d = sda_low_q;
        q_enter   = 1'b0;
        q_last    = (qcnt_q == Q_LAST) && !hold;

        case (state_q)
            S_IDLE: begin
                if (bus.I_CMD_VALID) begin
                    cmd_d     = cmd_e'(bus.I_CMD);
                    tx_d      = bus.I_DATA_TX;
                    ack_tx_d  = bus.I_ACK_TX;
                    qcnt_d    = '0;
                    quarter_d = 2'd0;
                    bit_d     = BIT_MSB;
                    q_enter   = 1'b1;
                    case (cmd_e'(bus.I_CMD))
                        CMD_START: state_d = S_START;
                        CMD_STOP:  state_d = S_STOP;
                        default:   state_d = S_BIT;
                    endcase
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                if (!hold) begin
                    if (!q_last) begin
                        qcnt_d = qcnt_q + QW'(1);
                    end else begin
                        qcnt_d    = '0;
                        quarter_d = quarter_q + 2'd1;
                        q_enter   = 1'b1;

                        // End of Q2 is the middle of the SCL-high phase.
                        if (quarter_q == 2'd2) begin
                            if (state_q == S_BIT && cmd_q == CMD_READ) begin
                                rx_sh_d = {rx_sh_q[P_DATA_WIDTH-2:0], sda_in};
                            end
                            if (state_q == S_ACK && cmd_q == CMD_WRITE) begin
                                ack_rx_d = sda_in;
                            end
                        end

                        if (quarter_q == 2'd3) begin
                            case (state_q)
                                S_START, S_STOP: state_d = S_DONE;
                                S_BIT: begin
                                    if (bit_q == '0) begin
                                        state_d = S_ACK;
                                    end else begin
                                        bit_d = bit_q - BW'(1);
                                    end
                                end
                                S_ACK: begin
                                    state_d = S_DONE;
                                    if (cmd_q == CMD_READ) begin
                                        data_rx_d = rx_sh_q;
                                    end
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end
                    end
                end
            end
        endcase

        // Line levels only change when a new quarter (or DONE) is entered.
        if (q_enter) begin
            case (state_d)
                S_START: begin
                    case (quarter_d)
                        2'd0: sda_low_d = 1'b0;
                        2'd1: begin scl_d = 1'b1; sda_low_d = 1'b0; end
                        2'd2: begin scl_d = 1'b1; sda_low_d = 1'b1; end
                        default: begin scl_d = 1'b0; sda_low_d = 1'b1; end
                    endcase
                end
                S_BIT: begin
                    scl_d     = quarter_d[1];
                    sda_low_d = (cmd_d == CMD_WRITE) && !tx_d[bit_d];
                end
                S_ACK: begin
                    scl_d     = quarter_d[1];
                    sda_low_d = (cmd_d == CMD_READ) && !ack_tx_d;
                end
                S_STOP: begin
                    case (quarter_d)
                        2'd0: begin scl_d = 1'b0; sda_low_d = 1'b1; end
                        2'd1: begin scl_d = 1'b1; sda_low_d = 1'b1; end
                        default: begin scl_d = 1'b1; sda_low_d = 1'b0; end
                    endcase
                end
                S_DONE: begin
                    // A byte transfer leaves SCL low so the bus stays owned.
                    if (state_q == S_ACK) begin
                        scl_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.O_CMD_READY = (state_q == S_IDLE);
    assign bus.O_BUSY      = (state_q == S_START) || (state_q == S_BIT) ||
                             (state_q == S_ACK)   || (state_q == S_STOP);
    assign bus.O_DONE      = (state_q == S_DONE);
    assign bus.O_DATA_RX   = data_rx_q;
    assign bus.O_ACK_RX    = ack_rx_q;
    assign bus.O_SCL       = scl_q;

    // Open-drain: pull low or release.
    assign IO_SDA = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master with a small I2C slave model.
`timescale 1ns/1ps

module tb_i2c_byte_master;

    localparam int Q = 4;
    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_STOP  = 2'd3;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] tx;
        logic       ack_tx;
        int         slave;      // 0 none, 1 ACK a write, 2 return sbyte
        logic [7:0] sbyte;
        int         exp_busy;
        int         tol;
        logic       exp_ack_rx;
        logic [7:0] exp_data_rx;
        int         poke;       // assert I_CMD_VALID while busy
    } vec_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic slave_low = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    logic scl_in_drv = 1'b1;
`endif
    wire  sda;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_start  = 0;
    int   n_stop   = 0;
    int   gen      = 0;
    logic sda_samples[$];
    vec_t exp_q[$];
    vec_t tbl[11];

    i2c_byte_master_if bus ();

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    i2c_byte_master #(.P_QUARTER(Q)) dut (
        .I_CLK    (clk),
        .I_NRESET (rst_n),
        .IO_SDA   (sda),
`ifdef I2C_CLK_STRETCH_EN
        .I_SCL_IN (scl_in_drv),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge bus.O_SCL) sda_samples.push_back(sda);
    always @(negedge sda) if (bus.O_SCL === 1'b1) n_start++;
    always @(posedge sda) if (bus.O_SCL === 1'b1) n_stop++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic slave_run(input int mode, input logic [7:0] b, input int my_gen);
        if (mode == 1) begin
            repeat (8) @(posedge bus.O_SCL);
            @(negedge bus.O_SCL);
            if (my_gen == gen) slave_low = 1'b1;
            @(negedge bus.O_SCL);
            if (my_gen == gen) slave_low = 1'b0;
        end else if (mode == 2) begin
            for (int i = 7; i >= 0; i--) begin
                if (my_gen == gen) slave_low = ~b[i];
                @(negedge bus.O_SCL);
            end
            if (my_gen == gen) slave_low = 1'b0;
        end
    endtask

    function automatic logic [8:0] exp_bits(input vec_t v);
        if (v.cmd == C_WRITE) return {v.tx, (v.slave == 1) ? 1'b0 : 1'b1};
        return {v.sbyte, v.ack_tx};
    endfunction

    task automatic do_cmd(input vec_t v, input string tag);
        vec_t       e;
        int         busy_cnt, guard, extra, st0, sp0, g;
        logic [8:0] obs;
        gen++;
        g         = gen;
        slave_low = 1'b0;
        sda_samples.delete();
        st0 = n_start;
        sp0 = n_stop;
        exp_q.push_back(v);
        fork
            slave_run(v.slave, v.sbyte, g);
        join_none
        @(negedge clk);
        check({tag, "_ready_idle"}, bus.O_CMD_READY, 1);
        bus.I_CMD_VALID = 1'b1;
        bus.I_CMD       = v.cmd;
        bus.I_DATA_TX   = v.tx;
        bus.I_ACK_TX    = v.ack_tx;
        @(negedge clk);
        bus.I_CMD_VALID = 1'b0;
        busy_cnt = 0;
        guard    = 0;
        while (bus.O_DONE !== 1'b1 && guard < 2000) begin
            if (bus.O_BUSY === 1'b1) busy_cnt++;
            if (v.poke != 0 && busy_cnt == 40 && bus.I_CMD_VALID == 1'b0) begin
                check({tag, "_ready_while_busy"}, bus.O_CMD_READY, 0);
                bus.I_CMD       = C_START;
                bus.I_CMD_VALID = 1'b1;
            end else begin
                bus.I_CMD_VALID = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.I_CMD_VALID = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_done_seen"}, (guard < 2000), 1);
        check_rng({tag, "_busy_cycles"}, busy_cnt, e.exp_busy, e.exp_busy + e.tol);
        check({tag, "_busy_in_done"}, bus.O_BUSY, 0);
        check({tag, "_ack_rx"}, bus.O_ACK_RX, e.exp_ack_rx);
        check({tag, "_data_rx"}, bus.O_DATA_RX, e.exp_data_rx);
        if (e.cmd == C_WRITE || e.cmd == C_READ) begin
            check({tag, "_scl_rises"}, sda_samples.size(), 9);
            obs = '0;
            for (int i = 0; i < 9 && i < sda_samples.size(); i++)
                obs = {obs[7:0], sda_samples[i]};
            check({tag, "_sda_bits"}, obs, exp_bits(e));
            check({tag, "_scl_low_after"}, bus.O_SCL, 0);
        end
        if (e.cmd == C_START) check({tag, "_start_cond"}, n_start - st0, 1);
        check({tag, "_stop_cond"}, n_stop - sp0, (e.cmd == C_STOP) ? 1 : 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.O_DONE, 0);
        check({tag, "_ready_after"}, bus.O_CMD_READY, 1);
        if (e.poke != 0) begin
            extra = 0;
            repeat (30) begin
                @(negedge clk);
                if (bus.O_DONE === 1'b1 || bus.O_BUSY === 1'b1) extra++;
            end
            check({tag, "_ignored_cmd"}, extra, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bus.I_CMD_VALID = 1'b0;
        bus.I_CMD       = 2'd0;
        bus.I_DATA_TX   = 8'h00;
        bus.I_ACK_TX    = 1'b0;

        //        cmd      tx     ackt slv sbyte  busy  tol ackrx data   poke
        tbl[0]  = '{C_START, 8'h00, 1'b0, 0, 8'h00, 4*Q,  0, 1'b1, 8'h00, 0};
        tbl[1]  = '{C_WRITE, 8'hA5, 1'b0, 1, 8'h00, 36*Q, 0, 1'b0, 8'h00, 0};
        tbl[2]  = '{C_WRITE, 8'h3C, 1'b0, 0, 8'h00, 36*Q, 0, 1'b1, 8'h00, 0};
        tbl[3]  = '{C_START, 8'h00, 1'b0, 0, 8'h00, 4*Q,  0, 1'b1, 8'h00, 0};
        tbl[4]  = '{C_READ,  8'h00, 1'b1, 2, 8'h5E, 36*Q, 0, 1'b1, 8'h5E, 1};
        tbl[5]  = '{C_READ,  8'h00, 1'b0, 2, 8'h81, 36*Q, 0, 1'b1, 8'h81, 0};
        tbl[6]  = '{C_STOP,  8'h00, 1'b0, 0, 8'h00, 4*Q,  0, 1'b1, 8'h81, 0};
        tbl[7]  = '{C_STOP,  8'h00, 1'b0, 0, 8'h00, 4*Q,  0, 1'b1, 8'h81, 0};
        tbl[8]  = '{C_WRITE, 8'h00, 1'b0, 1, 8'h00, 36*Q, 0, 1'b0, 8'h81, 0};
        tbl[9]  = '{C_READ,  8'h00, 1'b1, 2, 8'hFF, 36*Q, 0, 1'b0, 8'hFF, 0};
        tbl[10] = '{C_STOP,  8'h00, 1'b0, 0, 8'h00, 4*Q,  0, 1'b0, 8'hFF, 0};

        repeat (3) @(negedge clk);
        check("rst_scl", bus.O_SCL, 1);
        check("rst_busy", bus.O_BUSY, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_scl", bus.O_SCL, 1);
        check("idle_sda", sda, 1);
        check("idle_ready", bus.O_CMD_READY, 1);
        check("idle_done", bus.O_DONE, 0);
        check("idle_data_rx", bus.O_DATA_RX, 8'h00);
        check("idle_ack_rx", bus.O_ACK_RX, 1);

        for (int i = 0; i < 11; i++) do_cmd(tbl[i], $sformatf("v%0d", i));

        check("stop_final_scl", bus.O_SCL, 1);
        check("stop_final_sda", sda, 1);

        // Reset asserted between clock edges in the middle of a WRITE.
        gen++;
        slave_low = 1'b0;
        @(negedge clk);
        bus.I_CMD_VALID = 1'b1;
        bus.I_CMD       = C_WRITE;
        bus.I_DATA_TX   = 8'h0F;
        @(negedge clk);
        bus.I_CMD_VALID = 1'b0;
        repeat (30) @(negedge clk);
        check("midw_busy_before", bus.O_BUSY, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_scl", bus.O_SCL, 1);
        check("midrst_sda", sda, 1);
        check("midrst_busy", bus.O_BUSY, 0);
        check("midrst_ready", bus.O_CMD_READY, 1);
        check("midrst_done", bus.O_DONE, 0);
        check("midrst_data_rx", bus.O_DATA_RX, 8'h00);
        check("midrst_ack_rx", bus.O_ACK_RX, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        v = '{C_STOP, 8'h00, 1'b0, 0, 8'h00, 4*Q, 0, 1'b1, 8'h00, 0};
        do_cmd(v, "recover_stop");
        check("recover_scl", bus.O_SCL, 1);
        check("recover_sda", sda, 1);

`ifdef I2C_CLK_STRETCH_EN
        fork
            begin
                repeat (4) @(posedge bus.O_SCL);
                repeat (2) @(negedge clk);
                scl_in_drv = 1'b0;
                repeat (20) @(negedge clk);
                scl_in_drv = 1'b1;
            end
        join_none
        v = '{C_WRITE, 8'h5A, 1'b0, 1, 8'h00, 36*Q + 20, 3, 1'b0, 8'h00, 0};
        do_cmd(v, "stretch");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
